// File: rtl/leaf_net_adapter.sv
// ---------------------------------------------------------------------------
// leaf_net_adapter
//
// Purpose:
//   Connects a network switch port to a flow-control stage.
//   - Inbound: net_in is registered onto stream_in with one cycle of latency.
//     There is no filtering and no stall.
//   - Outbound: valid stream_out packets are written into a small FIFO.
//     The FIFO head is presented on net_out and popped by net_out_ack.
//     A valid packet that arrives while the FIFO is full, with no pop in the
//     same cycle, is dropped. resend then pulses for one cycle so the
//     flow-control stage re-issues that packet.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-low reset
//   net_in       in   [PACKET_BITS]   packet from the network switch
//   stream_in    out  [PACKET_BITS]   registered net_in
//   stream_out   in   [PACKET_BITS]   packet from the flow-control stage
//   resend       out  1               one-cycle pulse after each drop
//   net_out      out  [PACKET_BITS]   FIFO head, all zeros when empty
//   net_out_ack  in   1               network accepted net_out this cycle
//   fifo_level   out  [FIFO_DEPTH_BITS+1] outbound occupancy
//   drop_count   out  [16]            saturating drop counter
//                                     (only with LEAF_NET_DROP_COUNT_EN)
//
// Bit PACKET_BITS-1 of every packet is its valid flag.
//
// Optional feature macro: LEAF_NET_DROP_COUNT_EN
// ---------------------------------------------------------------------------
module leaf_net_adapter #(
    parameter int PACKET_BITS     = 97,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PACKET_BITS-1:0]     net_in,
    output logic [PACKET_BITS-1:0]     stream_in,
    input  logic [PACKET_BITS-1:0]     stream_out,
    output logic                       resend,
    output logic [PACKET_BITS-1:0]     net_out,
    input  logic                       net_out_ack,
    output logic [FIFO_DEPTH_BITS:0]   fifo_level
`ifdef LEAF_NET_DROP_COUNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] LEVEL_FULL = (FIFO_DEPTH_BITS + 1)'(DEPTH);

    logic [PACKET_BITS-1:0]     r_stream_in;
    logic [PACKET_BITS-1:0]     r_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   r_level;
    logic                       r_resend;

    logic w_in_valid;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_in_valid = stream_out[PACKET_BITS-1];
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LEVEL_FULL);
    // An ack on an empty FIFO has nothing to pop and is ignored.
    assign w_pop      = net_out_ack && !w_empty;
    // When full, a same-cycle pop frees the slot being written. The write
    // pointer equals the read pointer then, and the pop only moves the read
    // pointer, so order is preserved.
    assign w_push     = w_in_valid && (!w_full || w_pop);
    assign w_drop     = w_in_valid && w_full && !w_pop;

    // Inbound register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stream_in <= '0;
        end else begin
            r_stream_in <= net_in;
        end
    end

    // FIFO storage. Data is not reset; emptiness is tracked by r_level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= stream_out;
        end
    end

    // FIFO control: pointers wrap naturally at their width
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_resend <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_resend <= w_drop;
        end
    end

`ifdef LEAF_NET_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign stream_in  = r_stream_in;
    assign resend     = r_resend;
    assign fifo_level = r_level;
    assign net_out    = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_leaf_net_adapter.sv
module tb_leaf_net_adapter;

    localparam int PW = 97;
    localparam int DB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] net_in;
    logic [PW-1:0] stream_in;
    logic [PW-1:0] stream_out;
    logic          resend;
    logic [PW-1:0] net_out;
    logic          net_out_ack;
    logic [DB:0]   fifo_level;
`ifdef LEAF_NET_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    leaf_net_adapter #(.PACKET_BITS(PW), .FIFO_DEPTH_BITS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .net_in     (net_in),
        .stream_in  (stream_in),
        .stream_out (stream_out),
        .resend     (resend),
        .net_out    (net_out),
        .net_out_ack(net_out_ack),
        .fifo_level (fifo_level)
`ifdef LEAF_NET_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    function automatic logic [PW-1:0] pk(input int n);
        pk = {1'b1, 96'(n)};
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted net_out must match the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b1 && net_out_ack === 1'b1 && net_out[PW-1] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got %h expected none", net_out);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                if (net_out !== e) begin
                    failures++;
                    $display("FAIL pop_order: got %h expected %h", net_out, e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] v;
        reset       = 1'b0;
        net_in      = '0;
        stream_out  = '0;
        net_out_ack = 1'b0;

        // Reset state, also with activity on the inputs
        #3;
        chk("rst_stream_in", stream_in, '0);
        chk("rst_net_out", net_out, '0);
        chk("rst_resend", PW'(resend), '0);
        chk("rst_level", PW'(fifo_level), '0);
        net_in     = pk(7);
        stream_out = pk(8);
        step();
        step();
        chk("rst_hold_stream_in", stream_in, '0);
        chk("rst_hold_level", PW'(fifo_level), '0);
        net_in     = '0;
        stream_out = '0;
        reset      = 1'b1;

        // Inbound latency
        v = '0;
        v[64] = 1'b1;
        v[7:0] = 8'hAB;
        net_in = v;
        step();
        chk("in_lat_n1", stream_in, v);
        net_in = '0;
        step();
        chk("in_lat_n2", stream_in, '0);

        // Fill and drop
        for (int i = 1; i <= 5; i++) begin
            stream_out = pk(i);
            if (i <= 4) exp_q.push_back(pk(i));
            step();
        end
        chk("fill_level", PW'(fifo_level), PW'(4));
        chk("drop_resend", PW'(resend), PW'(1));
        chk("fill_head", net_out, pk(1));
`ifdef LEAF_NET_DROP_COUNT_EN
        chk("drop_count1", PW'(drop_count), PW'(1));
`endif
        stream_out = '0;
        step();
        chk("resend_pulse_end", PW'(resend), '0);

        // Full with same-cycle pop: no drop
        stream_out  = pk(6);
        net_out_ack = 1'b1;
        exp_q.push_back(pk(6));
        step();
        chk("fullpop_level", PW'(fifo_level), PW'(4));
        chk("fullpop_resend", PW'(resend), '0);
        chk("fullpop_head", net_out, pk(2));
        stream_out = '0;
        for (int i = 0; i < 4; i++) step();
        chk("drain_level", PW'(fifo_level), '0);

        // Empty ack and invalid input
        stream_out = {1'b0, 96'hDEAD};
        step();
        chk("empty_level", PW'(fifo_level), '0);
        chk("empty_net_out", net_out, '0);
        chk("empty_resend", PW'(resend), '0);

        // Wrap and order with continuous ack
        for (int i = 1; i <= 11; i++) begin
            if (i <= 10) begin
                stream_out = pk(100 + i);
                exp_q.push_back(pk(100 + i));
            end else begin
                stream_out = '0;
            end
            step();
            checks++;
            if (fifo_level > 2) begin
                failures++;
                $display("FAIL wrap_level: got %0d expected <=2", fifo_level);
            end
        end
        chk("wrap_end_level", PW'(fifo_level), '0);
        net_out_ack = 1'b0;

        // Reset mid-operation with three buffered packets
        for (int i = 1; i <= 3; i++) begin
            stream_out = pk(200 + i);
            step();
        end
        stream_out = '0;
        net_in     = pk(9);
        step();
        chk("pre_rst_level", PW'(fifo_level), PW'(3));
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_net_out", net_out, '0);
        chk("midrst_level", PW'(fifo_level), '0);
        chk("midrst_stream_in", stream_in, '0);
        net_in = '0;
        step();
        reset = 1'b1;
        chk("post_rst_level", PW'(fifo_level), '0);

        // First write after release is accepted on the first edge
        stream_out = pk(300);
        exp_q.push_back(pk(300));
        step();
        chk("first_write_level", PW'(fifo_level), PW'(1));
        stream_out  = '0;
        net_out_ack = 1'b1;
        step();
        net_out_ack = 1'b0;

        // Pending resend cancelled by reset
        for (int i = 1; i <= 5; i++) begin
            stream_out = pk(400 + i);
            step();
        end
        stream_out = '0;
        chk("cancel_pre_resend", PW'(resend), PW'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("cancel_resend", PW'(resend), '0);
`ifdef LEAF_NET_DROP_COUNT_EN
        chk("cancel_drop_count", PW'(drop_count), '0);
`endif
        step();
        reset = 1'b1;
        step();
        chk("cancel_after_resend", PW'(resend), '0);

        chk("scoreboard_empty", PW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leaf_net_adapter.md
LEAF_NET_ADAPTER -- requirements
Module: leaf_net_adapter

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 97: packet width; bit PACKET_BITS-1 is the valid flag.
REQ-002 SHALL have parameter FIFO_DEPTH_BITS, default 2: outbound FIFO depth is 2**FIFO_DEPTH_BITS (4).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port net_in  input  PACKET_BITS  packet from the network switch.
REQ-006 SHALL have port stream_in  output  PACKET_BITS  registered packet to the flow-control stage.
REQ-007 SHALL have port stream_out  input  PACKET_BITS  packet from the flow-control stage.
REQ-008 SHALL have port resend  output  1  request to the flow-control stage to re-issue its last packet.
REQ-009 SHALL have port net_out  output  PACKET_BITS  FIFO head to the network; valid flag = FIFO non-empty.
REQ-010 SHALL have port net_out_ack  input  1  network accepted net_out this cycle.
REQ-011 SHALL have port fifo_level  output  FIFO_DEPTH_BITS+1  current outbound occupancy.

Function
REQ-012 Inbound path SHALL register net_in to stream_in with exactly 1 cycle latency, no filtering, no stall.
REQ-013 stream_out with valid flag 1 SHALL be written to the outbound FIFO when the FIFO is not full, or when it is full and net_out_ack pops in the same cycle.
REQ-014 A valid stream_out arriving while full with no same-cycle pop SHALL be dropped, and resend SHALL be 1 on the following cycle only (one-cycle pulse per dropped packet).
REQ-015 stream_out with valid flag 0 SHALL never be written and SHALL never cause resend.
REQ-016 net_out SHALL present the FIFO head combinationally from storage; when the FIFO is empty, net_out SHALL be all zeros.
REQ-017 net_out_ack while empty SHALL be ignored; read pointer and level SHALL not change.
REQ-018 Pointers SHALL be FIFO_DEPTH_BITS wide and wrap modulo depth; fifo_level SHALL equal writes minus pops, range 0..depth.
REQ-019 Simultaneous write and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-020 Packets SHALL leave net_out in arrival order, with payload bits unmodified.

Reset
REQ-021 While reset=0, stream_in, net_out and resend SHALL be 0, fifo_level SHALL be 0, and pointers SHALL be 0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard all buffered packets; a pending resend pulse SHALL be cancelled.
REQ-023 The first write after reset release SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-024 With macro LEAF_NET_DROP_COUNT_EN defined, the module SHALL add output drop_count (16 bits): reset to 0, incremented on each drop per REQ-014, saturating at 0xFFFF.
REQ-025 Without LEAF_NET_DROP_COUNT_EN, drop_count and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-026 Inbound latency: net_in=0x1_0000_0000_0000_00AB at cycle N -> stream_in equals that value at cycle N+1 and 0 at N+2 when net_in returns to 0.
REQ-027 Fill and drop: 5 back-to-back valid stream_out packets, net_out_ack=0 -> fifo_level=4; 5th packet dropped; resend=1 for exactly one cycle; drop_count=1 when the macro is defined.
REQ-028 Full with pop: FIFO full, valid stream_out and net_out_ack in the same cycle -> no drop, resend=0, fifo_level stays 4, oldest packet removed.
REQ-029 Wrap and order: push packets 1..10 while acking continuously -> net_out yields 1..10 in order; fifo_level never exceeds 2.
REQ-030 Empty ack and invalid input: net_out_ack=1 with FIFO empty and stream_out valid flag 0 -> fifo_level=0, net_out=0, resend=0.
REQ-031 Reset mid-operation: FIFO holding 3 packets, assert reset for 1 cycle asynchronously -> outputs 0 immediately; after release, fifo_level=0.
